// File: rtl/vdecoder.sv
// vdecoder: hard-decision Viterbi decoder for the 4-state rate-1/2 code
// (generators 111 / 110). Pairs serial symbols c0,c1, runs add-compare-select
// over the four states and keeps register-exchange survivors of depth TB.
module vdecoder #(
    parameter int unsigned TB = 15,
    parameter int unsigned MW = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    input  logic in_valid,
    output logic out,
    output logic out_valid
);

    localparam int unsigned   CW    = $clog2(TB);
    localparam logic [MW-1:0] MMAX  = '1;
    localparam logic [CW-1:0] CLAST = CW'(TB - 1);

    typedef enum logic {PH_C0, PH_C1} phase_t;

    phase_t              phase, phase_nxt;
    logic                c0_q;
    logic                pair_edge;
    logic [CW-1:0]       paircnt;
    logic [3:0][MW-1:0]  metric, metric_nxt;
    logic [3:0][TB-1:0]  path, path_nxt;
    logic [1:0]          best;

    // Hamming distance between the received pair and the branch label for
    // source state s with information bit b.
    function automatic logic [1:0] branch(input logic [1:0] s, input logic b,
                                          input logic r0, input logic r1);
        logic e0;
        logic e1;
        e0 = b ^ s[1] ^ s[0];
        e1 = b ^ s[1];
        return {1'b0, e0 ^ r0} + {1'b0, e1 ^ r1};
    endfunction

    // Metric plus branch cost, clamped to the largest representable value.
    function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] m, input logic [1:0] d);
        logic [MW:0] sum;
        sum = {1'b0, m} + {{(MW-1){1'b0}}, d};
        return (sum > {1'b0, MMAX}) ? MMAX : sum[MW-1:0];
    endfunction

    // Symbol phase: toggles on every accepted symbol; phase 1 completes a pair.
    always_comb begin
        phase_nxt = phase;
        if (in_valid) begin
            phase_nxt = (phase == PH_C0) ? PH_C1 : PH_C0;
        end
    end

    assign pair_edge = in_valid && (phase == PH_C1);

    // ACS for all four next states, then best-state pick and normalization.
    always_comb begin
        logic [1:0]         nsb;
        logic [1:0]         p0;
        logic [1:0]         p1;
        logic [MW-1:0]      cand0;
        logic [MW-1:0]      cand1;
        logic [MW-1:0]      mmin;
        logic [3:0][MW-1:0] acs_m;
        acs_m    = '0;
        path_nxt = '0;
        for (int unsigned ns = 0; ns < 4; ns++) begin
            nsb   = 2'(ns);
            p0    = {nsb[0], 1'b0};
            p1    = {nsb[0], 1'b1};
            cand0 = sat_add(metric[p0], branch(p0, nsb[1], c0_q, in));
            cand1 = sat_add(metric[p1], branch(p1, nsb[1], c0_q, in));
            // Ties resolve to the {a,0} predecessor.
            if (cand1 < cand0) begin
                acs_m[ns]    = cand1;
                path_nxt[ns] = {path[p1][TB-2:0], nsb[1]};
            end else begin
                acs_m[ns]    = cand0;
                path_nxt[ns] = {path[p0][TB-2:0], nsb[1]};
            end
        end
        best = '0;
        mmin = acs_m[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if (acs_m[i] < mmin) begin
                mmin = acs_m[i];
                best = 2'(i);
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            metric_nxt[i] = acs_m[i] - mmin;
        end
    end

    // State register: symbol pairing, metrics, survivors, pair count, output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase     <= PH_C0;
            c0_q      <= 1'b0;
            metric    <= {MMAX, MMAX, MMAX, {MW{1'b0}}};
            path      <= '0;
            paircnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            out_valid <= 1'b0;
            if (in_valid && (phase == PH_C0)) begin
                c0_q <= in;
            end
            if (pair_edge) begin
                metric <= metric_nxt;
                path   <= path_nxt;
                if (paircnt != CLAST) begin
                    paircnt <= paircnt + CW'(1);
                end else begin
                    out_valid <= 1'b1;
                    out       <= path_nxt[best][TB-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_vdecoder.sv
// tb_vdecoder: directed-vector bench for vdecoder (TB=15, MW=4).
module tb_vdecoder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in = 1'b0;
    logic in_valid = 1'b0;
    logic out;
    logic out_valid;

    vdecoder #(.TB(15), .MW(4)) dut (
        .clock(clock),
        .reset(reset),
        .in(in),
        .in_valid(in_valid),
        .out(out),
        .out_valid(out_valid)
    );

    always #5 clock = ~clock;

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Monitor state
    int   acc_syms   = 0;
    int   since_acc  = 0;
    int   first_syms = -1;
    int   wide_cnt   = 0;
    int   late_cnt   = 0;
    int   m0_bad     = 0;
    int   z_bad      = 0;
    bit   prev_ov    = 1'b0;
    bit   long_mode  = 1'b0;
    logic obits[$];

    // Count accepted symbols and cycles since the last one.
    always @(posedge clock) begin
        if (!reset) begin
            acc_syms  <= 0;
            since_acc <= 0;
        end else if (in_valid) begin
            acc_syms  <= acc_syms + 1;
            since_acc <= 0;
        end else begin
            since_acc <= since_acc + 1;
        end
    end

    // Collect output strobes away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            first_syms <= -1;
            wide_cnt   <= 0;
            late_cnt   <= 0;
            m0_bad     <= 0;
            z_bad      <= 0;
            prev_ov    <= 1'b0;
            obits.delete();
        end else begin
            if (out_valid) begin
                obits.push_back(out);
                if (first_syms < 0) first_syms <= acc_syms;
                if (since_acc != 0) late_cnt <= late_cnt + 1;
                if (prev_ov) wide_cnt <= wide_cnt + 1;
                if (long_mode && out != 1'b0) z_bad <= z_bad + 1;
            end
            prev_ov <= out_valid;
            if (long_mode && dut.metric[0] != 4'd0) m0_bad <= m0_bad + 1;
        end
    end

    logic syms[$];
    logic exp_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // u = 1,0,1,1 then 18 zeros; optionally flip c1 of pair 5.
    task automatic build(input bit flip);
        logic [1:0] s;
        logic b;
        logic c0;
        logic c1;
        syms.delete();
        s = 2'b00;
        for (int k = 0; k < 22; k++) begin
            b  = (k == 0 || k == 2 || k == 3);
            c0 = b ^ s[1] ^ s[0];
            c1 = b ^ s[1];
            if (flip && k == 5) c1 = ~c1;
            syms.push_back(c0);
            syms.push_back(c1);
            s = {b, s[1]};
        end
    endtask

    task automatic sym(input logic s);
        @(negedge clock);
        in       = s;
        in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
            in       = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run(input string nm, input bit flip, input bit gapped, input int rst_at);
        int n;
        build(flip);
        do_reset();
        if (rst_at > 0) begin
            for (int i = 0; i < rst_at; i++) sym(syms[i]);
            @(negedge clock);
            reset    = 1'b0;
            in_valid = 1'b1;
            in       = ~in;
            @(negedge clock);
            reset    = 1'b1;
            in_valid = 1'b0;
        end
        for (int i = 0; i < syms.size(); i++) begin
            sym(syms[i]);
            if (gapped) idle(int'($urandom_range(0, 3)));
        end
        idle(4);
        check({nm, " count"}, obits.size(), 8);
        n = (obits.size() < 8) ? obits.size() : 8;
        for (int k = 0; k < n; k++) check($sformatf("%s bit%0d", nm, k), obits[k], exp_bits[k]);
        check({nm, " first_syms"}, first_syms, 30);
        check({nm, " wide"}, wide_cnt, 0);
        check({nm, " late"}, late_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held low with activity on the input.
        reset    = 1'b0;
        in_valid = 1'b1;
        in       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("rst out%0d", k), out, 0);
            check($sformatf("rst ov%0d", k), out_valid, 0);
            in = ~in;
        end
        check("rst m0", dut.metric[0], 0);
        check("rst m1", dut.metric[1], 15);
        check("rst m2", dut.metric[2], 15);
        check("rst m3", dut.metric[3], 15);

        run("clean",  1'b0, 1'b0, 0);
        run("error",  1'b1, 1'b0, 0);
        run("gapped", 1'b0, 1'b1, 0);
        run("midrst", 1'b0, 1'b0, 7);

        // Long all-zero stream; first pair exercises metric saturation.
        do_reset();
        long_mode = 1'b1;
        sym(1'b0);
        sym(1'b0);
        idle(1);
        check("zero p1 m1", dut.metric[1], 15);
        check("zero p1 m2", dut.metric[2], 2);
        check("zero p1 m3", dut.metric[3], 15);
        for (int p = 1; p < 1000; p++) begin
            sym(1'b0);
            sym(1'b0);
        end
        idle(4);
        long_mode = 1'b0;
        check("zero count", obits.size(), 986);
        check("zero outs", z_bad, 0);
        check("zero m0", m0_bad, 0);
        check("zero m1", dut.metric[1], 3);
        check("zero m2", dut.metric[2], 2);
        check("zero m3", dut.metric[3], 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
